// File: rtl/tilt_pkg.sv
// rtl/tilt_pkg.sv - shared types, constants and slew helper for the tilt conditioner
package tilt_pkg;

    typedef enum logic [1:0] {
        ST_ACCUM   = 2'd0,
        ST_QUANT_X = 2'd1,
        ST_QUANT_Y = 2'd2,
        ST_PUBLISH = 2'd3
    } tilt_state_e;

    localparam int                 TILT_AMOUNT_W   = 4;
    localparam logic [TILT_AMOUNT_W-1:0] TILT_AMOUNT_MAX = 4'd15;

    // One publish worth of movement toward the target: a direction reversal
    // first walks the amount down to zero, then flips and starts climbing.
    // Result is {direction, amount}.
    function automatic logic [TILT_AMOUNT_W:0] tilt_slew_step(
        input logic [TILT_AMOUNT_W-1:0] cur_amt,
        input logic                     cur_dir,
        input logic [TILT_AMOUNT_W-1:0] tgt_amt,
        input logic                     tgt_dir
    );
        logic [TILT_AMOUNT_W-1:0] amt;
        logic                     dir;
        amt = cur_amt;
        dir = cur_dir;
        if (cur_dir != tgt_dir) begin
            if (cur_amt != '0) begin
                amt = cur_amt - 1'b1;
            end else begin
                dir = tgt_dir;
                if (tgt_amt != '0) begin
                    amt = 4'd1;
                end
            end
        end else if (cur_amt < tgt_amt) begin
            amt = cur_amt + 1'b1;
        end else if (cur_amt > tgt_amt) begin
            amt = cur_amt - 1'b1;
        end
        return {dir, amt};
    endfunction

endpackage

// File: rtl/tilt_quantize.sv
// rtl/tilt_quantize.sv - combinational abs, deadzone, scale, saturate and direction
module tilt_quantize
    import tilt_pkg::*;
#(
    parameter int SAMPLE_W    = 12,
    parameter int DEADZONE    = 64,
    parameter int SCALE_SHIFT = 5
) (
    input  logic [SAMPLE_W-1:0]      avg_i,
    output logic [TILT_AMOUNT_W-1:0] amount_o,
    output logic                     direction_o
);

    // One extra bit so the magnitude of the most negative sample fits.
    localparam logic [SAMPLE_W:0] DZ_W  = (SAMPLE_W+1)'(DEADZONE);
    localparam logic [SAMPLE_W:0] MAX_W = (SAMPLE_W+1)'(TILT_AMOUNT_MAX);

    logic [SAMPLE_W:0] ext;
    logic [SAMPLE_W:0] mag;
    logic [SAMPLE_W:0] excess;
    logic [SAMPLE_W:0] scaled;

    // Magnitude, deadzone cut, scale down and clamp to the 4-bit range.
    always_comb begin
        amount_o    = '0;
        direction_o = 1'b0;
        excess      = '0;
        scaled      = '0;
        ext         = {avg_i[SAMPLE_W-1], avg_i};
        mag         = avg_i[SAMPLE_W-1] ? (~ext + 1'b1) : ext;
        if (mag > DZ_W) begin
            excess      = mag - DZ_W;
            scaled      = excess >> SCALE_SHIFT;
            amount_o    = (scaled > MAX_W) ? TILT_AMOUNT_MAX : scaled[TILT_AMOUNT_W-1:0];
            direction_o = ~avg_i[SAMPLE_W-1];
        end
    end

endmodule

// File: rtl/tilt_conditioner.sv
// rtl/tilt_conditioner.sv - accelerometer block-average, quantize and frame-aligned publish (optional TILT_SLEW_LIMIT_EN)
module tilt_conditioner
    import tilt_pkg::*;
#(
    parameter int SAMPLE_W    = 12,
    parameter int AVG_LOG2    = 3,
    parameter int DEADZONE    = 64,
    parameter int SCALE_SHIFT = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sample_valid,
    output logic                     sample_ready,
    input  logic                     sample_axis,
    input  logic [SAMPLE_W-1:0]      sample_data,
    input  logic                     frame_start,
    output logic [TILT_AMOUNT_W-1:0] tilt_amount_x,
    output logic                     tilt_direction_x,
    output logic [TILT_AMOUNT_W-1:0] tilt_amount_y,
    output logic                     tilt_direction_y,
    output logic                     tilt_valid
);

    localparam int ACC_W = SAMPLE_W + AVG_LOG2;

    tilt_state_e state_q, state_d;
    logic        frame_pending_q, frame_pending_d;

    logic [ACC_W-1:0]    acc_x_q, acc_y_q;
    logic [ACC_W-1:0]    sum_x, sum_y, sample_ext;
    logic [AVG_LOG2-1:0] cnt_x_q, cnt_y_q;
    logic [SAMPLE_W-1:0] avg_x_q, avg_y_q;
    logic [SAMPLE_W-1:0] quant_avg;
    logic                accept;

    logic [TILT_AMOUNT_W-1:0] q_amt;
    logic                     q_dir;
    logic [TILT_AMOUNT_W-1:0] tgt_amt_x_q, tgt_amt_y_q;
    logic                     tgt_dir_x_q, tgt_dir_y_q;
    logic [TILT_AMOUNT_W-1:0] amt_x_q, amt_y_q;
    logic                     dir_x_q, dir_y_q;
    logic                     valid_q;
    logic [TILT_AMOUNT_W:0]   next_x, next_y;

    assign sample_ready = (state_q == ST_ACCUM);
    assign accept       = sample_valid & sample_ready;
    assign sample_ext   = {{AVG_LOG2{sample_data[SAMPLE_W-1]}}, sample_data};
    assign sum_x        = acc_x_q + sample_ext;
    assign sum_y        = acc_y_q + sample_ext;

    // Per-axis block accumulation; dropping the low AVG_LOG2 bits of the
    // two's-complement sum is the arithmetic (floor) divide.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_x_q <= '0;
            acc_y_q <= '0;
            cnt_x_q <= '0;
            cnt_y_q <= '0;
            avg_x_q <= '0;
            avg_y_q <= '0;
        end else if (accept) begin
            if (!sample_axis) begin
                cnt_x_q <= cnt_x_q + 1'b1;
                if (cnt_x_q == '1) begin
                    avg_x_q <= sum_x[ACC_W-1:AVG_LOG2];
                    acc_x_q <= '0;
                end else begin
                    acc_x_q <= sum_x;
                end
            end else begin
                cnt_y_q <= cnt_y_q + 1'b1;
                if (cnt_y_q == '1) begin
                    avg_y_q <= sum_y[ACC_W-1:AVG_LOG2];
                    acc_y_q <= '0;
                end else begin
                    acc_y_q <= sum_y;
                end
            end
        end
    end

    // Next state, quantizer axis select and frame-pending bookkeeping.
    always_comb begin
        state_d         = state_q;
        frame_pending_d = frame_pending_q;
        quant_avg       = avg_x_q;
        case (state_q)
            ST_ACCUM: begin
                if (frame_start || frame_pending_q) begin
                    state_d         = ST_QUANT_X;
                    frame_pending_d = 1'b0;
                end
            end
            ST_QUANT_X: state_d = ST_QUANT_Y;
            ST_QUANT_Y: begin
                quant_avg = avg_y_q;
                state_d   = ST_PUBLISH;
            end
            ST_PUBLISH: state_d = ST_ACCUM;
            default:    state_d = ST_ACCUM;
        endcase
        if (frame_start && (state_q != ST_ACCUM)) begin
            frame_pending_d = 1'b1;
        end
    end

    // FSM state and pending-frame flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_ACCUM;
            frame_pending_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            frame_pending_q <= frame_pending_d;
        end
    end

    tilt_quantize #(
        .SAMPLE_W   (SAMPLE_W),
        .DEADZONE   (DEADZONE),
        .SCALE_SHIFT(SCALE_SHIFT)
    ) u_quantize (
        .avg_i      (quant_avg),
        .amount_o   (q_amt),
        .direction_o(q_dir)
    );

`ifdef TILT_SLEW_LIMIT_EN
    assign next_x = tilt_slew_step(amt_x_q, dir_x_q, tgt_amt_x_q, tgt_dir_x_q);
    assign next_y = tilt_slew_step(amt_y_q, dir_y_q, tgt_amt_y_q, tgt_dir_y_q);
`else
    assign next_x = {tgt_dir_x_q, tgt_amt_x_q};
    assign next_y = {tgt_dir_y_q, tgt_amt_y_q};
`endif

    // Capture per-axis targets, then move them onto the outputs at publish.
    always_ff @(posedge clk) begin
        if (rst) begin
            tgt_amt_x_q <= '0;
            tgt_dir_x_q <= 1'b0;
            tgt_amt_y_q <= '0;
            tgt_dir_y_q <= 1'b0;
            amt_x_q     <= '0;
            dir_x_q     <= 1'b0;
            amt_y_q     <= '0;
            dir_y_q     <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            valid_q <= (state_q == ST_PUBLISH);
            if (state_q == ST_QUANT_X) begin
                tgt_amt_x_q <= q_amt;
                tgt_dir_x_q <= q_dir;
            end
            if (state_q == ST_QUANT_Y) begin
                tgt_amt_y_q <= q_amt;
                tgt_dir_y_q <= q_dir;
            end
            if (state_q == ST_PUBLISH) begin
                dir_x_q <= next_x[TILT_AMOUNT_W];
                amt_x_q <= next_x[TILT_AMOUNT_W-1:0];
                dir_y_q <= next_y[TILT_AMOUNT_W];
                amt_y_q <= next_y[TILT_AMOUNT_W-1:0];
            end
        end
    end

    assign tilt_amount_x    = amt_x_q;
    assign tilt_direction_x = dir_x_q;
    assign tilt_amount_y    = amt_y_q;
    assign tilt_direction_y = dir_y_q;
    assign tilt_valid       = valid_q;

endmodule

// File: tb/tb_tilt_conditioner.sv
// tb/tb_tilt_conditioner.sv - randomized and directed check of tilt_conditioner against a frame-level model
module tb_tilt_conditioner;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_valid;
    logic        sample_ready;
    logic        sample_axis;
    logic [11:0] sample_data;
    logic        frame_start;
    logic [3:0]  tilt_amount_x;
    logic        tilt_direction_x;
    logic [3:0]  tilt_amount_y;
    logic        tilt_direction_y;
    logic        tilt_valid;

    always #5 clk = ~clk;

    tilt_conditioner dut (
        .clk             (clk),
        .rst             (rst),
        .sample_valid    (sample_valid),
        .sample_ready    (sample_ready),
        .sample_axis     (sample_axis),
        .sample_data     (sample_data),
        .frame_start     (frame_start),
        .tilt_amount_x   (tilt_amount_x),
        .tilt_direction_x(tilt_direction_x),
        .tilt_amount_y   (tilt_amount_y),
        .tilt_direction_y(tilt_direction_y),
        .tilt_valid      (tilt_valid)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: lists of pending samples, averages, and a countdown
    // of busy cycles after a frame is taken.
    int m_q[2][$];
    int m_avg[2];
    int m_tgt_amt[2], m_tgt_dir[2];
    int m_amt[2], m_dir[2];
    int m_busy;
    bit m_pending;
    bit m_valid;

    function automatic int floor_avg(input int s);
        if (s >= 0) return s / 8;
        return -((-s + 7) / 8);
    endfunction

    task automatic quant(input int avg, output int amt, output int dir);
        int mag;
        mag = (avg < 0) ? -avg : avg;
        if (mag <= 64) begin
            amt = 0;
            dir = 0;
        end else begin
            amt = (mag - 64) / 32;
            if (amt > 15) amt = 15;
            dir = (avg >= 0) ? 1 : 0;
        end
    endtask

    task automatic model_publish(input int a);
`ifdef TILT_SLEW_LIMIT_EN
        if (m_dir[a] != m_tgt_dir[a]) begin
            if (m_amt[a] > 0) m_amt[a]--;
            else begin
                m_dir[a] = m_tgt_dir[a];
                m_amt[a] = (m_tgt_amt[a] > 0) ? 1 : 0;
            end
        end else if (m_amt[a] < m_tgt_amt[a]) m_amt[a]++;
        else if (m_amt[a] > m_tgt_amt[a]) m_amt[a]--;
`else
        m_amt[a] = m_tgt_amt[a];
        m_dir[a] = m_tgt_dir[a];
`endif
    endtask

    task automatic model_reset();
        for (int a = 0; a < 2; a++) begin
            m_q[a].delete();
            m_avg[a] = 0; m_tgt_amt[a] = 0; m_tgt_dir[a] = 0;
            m_amt[a] = 0; m_dir[a] = 0;
        end
        m_busy = 0; m_pending = 0; m_valid = 0;
    endtask

    // One clock: drive, check ready, clock, advance model, check outputs.
    task automatic step(input bit v, input bit ax, input int data, input bit fs, input bit r);
        logic signed [11:0] d12;
        int sval, sum;
        d12          = data[11:0];
        sval         = d12;
        sample_valid = v;
        sample_axis  = ax;
        sample_data  = data[11:0];
        frame_start  = fs;
        rst          = r;
        check("sample_ready", sample_ready, (m_busy == 0) ? 1 : 0);
        @(posedge clk);
        #1;
        if (r) begin
            model_reset();
        end else begin
            m_valid = 0;
            if (m_busy == 0) begin
                if (v) begin
                    m_q[ax].push_back(sval);
                    if (m_q[ax].size() == 8) begin
                        sum = 0;
                        foreach (m_q[ax][i]) sum += m_q[ax][i];
                        m_avg[ax] = floor_avg(sum);
                        m_q[ax].delete();
                    end
                end
                if (fs || m_pending) begin
                    quant(m_avg[0], m_tgt_amt[0], m_tgt_dir[0]);
                    quant(m_avg[1], m_tgt_amt[1], m_tgt_dir[1]);
                    m_busy    = 3;
                    m_pending = 0;
                end
            end else begin
                if (fs) m_pending = 1;
                if (m_busy == 1) begin
                    model_publish(0);
                    model_publish(1);
                    m_valid = 1;
                end
                m_busy--;
            end
        end
        check("amount_x", tilt_amount_x, m_amt[0]);
        check("dir_x", tilt_direction_x, m_dir[0]);
        check("amount_y", tilt_amount_y, m_amt[1]);
        check("dir_y", tilt_direction_y, m_dir[1]);
        check("tilt_valid", tilt_valid, m_valid);
    endtask

    task automatic feed(input bit ax, input int val, input int n);
        for (int i = 0; i < n; i++) step(1, ax, val, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic frame();
        step(0, 0, 0, 1, 0);
        idle(4);
    endtask

    initial begin
        bit v, ax, fs, r;
        int data;
        sample_valid = 0; sample_axis = 0; sample_data = '0; frame_start = 0; rst = 1;
        model_reset();
        @(posedge clk);
        #1;
        step(0, 0, 0, 0, 1);
        check("reset_ready", sample_ready, 1);

        feed(0, 544, 8);
        step(0, 0, 0, 1, 0);
        idle(2);
        step(0, 0, 0, 0, 0);
        check("pub_valid_pulse", tilt_valid, 1);
        idle(1);
`ifndef TILT_SLEW_LIMIT_EN
        check("plan_x544_amt", tilt_amount_x, 15);
        check("plan_x544_dir", tilt_direction_x, 1);
`endif
        feed(1, -200, 8);
        frame();
`ifndef TILT_SLEW_LIMIT_EN
        check("plan_y200_amt", tilt_amount_y, 4);
        check("plan_y200_dir", tilt_direction_y, 0);
        check("plan_x_held", tilt_amount_x, 15);
`endif
        feed(0, 50, 8);
        frame();
`ifndef TILT_SLEW_LIMIT_EN
        check("plan_dead_amt", tilt_amount_x, 0);
        check("plan_dead_dir", tilt_direction_x, 0);
`endif
        feed(0, -2048, 8);
        frame();
`ifndef TILT_SLEW_LIMIT_EN
        check("plan_sat_amt", tilt_amount_x, 15);
        check("plan_sat_dir", tilt_direction_x, 0);
`endif
        feed(0, 160, 7);
        step(1, 0, 160, 1, 0);
        step(1, 0, 160, 0, 0);
        step(1, 0, 160, 0, 0);
        step(1, 0, 160, 0, 0);
`ifndef TILT_SLEW_LIMIT_EN
        check("plan_coinc_amt", tilt_amount_x, 3);
`endif
        idle(2);
        feed(0, 1000, 4);
        step(0, 0, 0, 0, 1);
        check("rst_amt_x", tilt_amount_x, 0);
        check("rst_amt_y", tilt_amount_y, 0);
        check("rst_valid", tilt_valid, 0);
        feed(0, 100, 8);
        frame();
`ifndef TILT_SLEW_LIMIT_EN
        check("plan_rst_amt", tilt_amount_x, 1);
`endif
        for (int i = 0; i < 3000; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            ax = $urandom_range(0, 1);
            if ($urandom_range(0, 1) != 0) data = $urandom_range(0, 4095);
            else data = $urandom_range(0, 600) - 300;
            fs = ($urandom_range(0, 19) == 0);
            r  = ($urandom_range(0, 499) == 0);
            step(v, ax, data, fs, r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
